// File: rtl/obuf_wr_arb_pkg.sv
// Shared OBuffer geometry and the write-beat bundle used by the write-port-2 arbiter.
package Common;

    localparam int unsigned OBufBank  = 4;
    localparam int unsigned OBufAddrW = 8;
    localparam int unsigned OBufWidth = 32;

    typedef logic [OBufBank-1:0][OBufAddrW-1:0] obuf_addr_vec_t;
    typedef logic [OBufBank-1:0][OBufWidth-1:0] obuf_data_vec_t;
    typedef logic [OBufBank-1:0]                obuf_en_t;

    typedef struct packed {
        obuf_addr_vec_t addr;
        obuf_en_t       en;
        obuf_data_vec_t data;
    } ObufWrBeat;

    // Round-robin owner: who wins the next both-valid conflict.
    typedef enum logic {
        PrioM = 1'b0,
        PrioV = 1'b1
    } arb_prio_e;

    // Two beats can share a cycle only when they touch disjoint banks.
    function automatic logic en_overlap(input obuf_en_t a, input obuf_en_t b);
        return (a & b) != '0;
    endfunction

endpackage

// File: rtl/obuf_wr_arb_if.sv
// Requester-side and OBuffer-side signals of the write-port-2 arbiter.
interface obuf_wr_arb_if;
    import Common::*;

    logic           mValid;
    logic           mReady;
    obuf_addr_vec_t mWAddr;
    obuf_en_t       mWEn;
    obuf_data_vec_t mWData;

    logic           vValid;
    logic           vReady;
    obuf_addr_vec_t vWAddr;
    obuf_en_t       vWEn;
    obuf_data_vec_t vWData;

    obuf_addr_vec_t oBufW2Addr;
    obuf_en_t       oBufW2En;
    obuf_data_vec_t oBufW2Data;
    logic           idle;

    modport master (
        output mValid, mWAddr, mWEn, mWData,
        output vValid, vWAddr, vWEn, vWData,
        input  mReady, vReady,
        input  oBufW2Addr, oBufW2En, oBufW2Data, idle
    );

    modport slave (
        input  mValid, mWAddr, mWEn, mWData,
        input  vValid, vWAddr, vWEn, vWData,
        output mReady, vReady,
        output oBufW2Addr, oBufW2En, oBufW2Data, idle
    );

endinterface

// File: rtl/obuf_wr_arb_rr_arb2.sv
// Two-way round-robin grant with a registered priority pointer (req/gnt bit 0 = MArray, bit 1 = vector unit).
module rr_arb2
    import Common::*;
#(
    parameter bit RST_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       conflict,
    output logic [1:0] gnt
);

    arb_prio_e ptr_q, ptr_d;

    // A single winner always hands priority to the other side; a shared grant leaves it alone.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        if (!rst) begin
            case (req)
                2'b01: begin
                    gnt   = 2'b01;
                    ptr_d = PrioV;
                end
                2'b10: begin
                    gnt   = 2'b10;
                    ptr_d = PrioM;
                end
                2'b11: begin
                    if (conflict) begin
                        if (ptr_q == PrioM) begin
                            gnt   = 2'b01;
                            ptr_d = PrioV;
                        end else begin
                            gnt   = 2'b10;
                            ptr_d = PrioM;
                        end
                    end else begin
                        gnt = 2'b11;
                    end
                end
                default: begin
                    gnt   = '0;
                    ptr_d = ptr_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= arb_prio_e'(RST_PRIO);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/obuf_wr_arb.sv
// Arbitrates MArray and vector-unit write beats onto OBuffer write port 2 with a one-cycle registered output.
// Define OBUF_ARB_MERGE_EN to let bank-disjoint beats from both requesters share one cycle.
module obuf_wr_arb
    import Common::*;
#(
    parameter bit RST_PRIO = 1'b0
) (
    input logic          clk,
    input logic          rst,
    obuf_wr_arb_if.slave bus
);

    logic [1:0] req;
    logic [1:0] gnt;
    logic       conflict;

    ObufWrBeat beat_d, beat_q;

    assign req = {bus.vValid, bus.mValid};

`ifdef OBUF_ARB_MERGE_EN
    assign conflict = en_overlap(bus.mWEn, bus.vWEn);
`else
    assign conflict = 1'b1;
`endif

    rr_arb2 #(
        .RST_PRIO (RST_PRIO)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .conflict (conflict),
        .gnt      (gnt)
    );

    assign bus.mReady = gnt[0];
    assign bus.vReady = gnt[1];

    // Banks not enabled by a granted beat stay zero so idle cycles and masked lanes look the same.
    always_comb begin
        beat_d = '0;
        for (int unsigned b = 0; b < OBufBank; b++) begin
            if (gnt[0] && bus.mWEn[b]) begin
                beat_d.en[b]   = 1'b1;
                beat_d.addr[b] = bus.mWAddr[b];
                beat_d.data[b] = bus.mWData[b];
            end else if (gnt[1] && bus.vWEn[b]) begin
                beat_d.en[b]   = 1'b1;
                beat_d.addr[b] = bus.vWAddr[b];
                beat_d.data[b] = bus.vWData[b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign bus.oBufW2Addr = beat_q.addr;
    assign bus.oBufW2En   = beat_q.en;
    assign bus.oBufW2Data = beat_q.data;

    assign bus.idle = rst | (!bus.mValid & !bus.vValid & (beat_q.en == '0));

endmodule

// File: tb/tb_obuf_wr_arb.sv
// Bench for obuf_wr_arb: directed pins followed by randomized traffic against a cycle-level reference model.
`timescale 1ns/1ps
module tb_obuf_wr_arb;
    import Common::*;

    localparam bit RST_PRIO = 1'b0;
`ifdef OBUF_ARB_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    obuf_wr_arb_if bus ();

    obuf_wr_arb #(
        .RST_PRIO (RST_PRIO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nerrors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: priority owner (0 = M, 1 = V) and the beat due on the output next cycle.
    int             m_ptr = int'(RST_PRIO);
    bit             exp_any = 1'b0;
    obuf_en_t       exp_en = '0;
    obuf_addr_vec_t exp_addr = '0;
    obuf_data_vec_t exp_data = '0;
    int             mwait = 0;
    int             vwait = 0;

    always @(negedge clk) begin : model_cmp
        logic gm, gv, conf;

        if (!exp_any) begin
            chk("w2_en_quiet", bus.oBufW2En, '0);
            chk("w2_addr_quiet", bus.oBufW2Addr, '0);
            chk("w2_data_quiet", bus.oBufW2Data, '0);
        end else begin
            chk("w2_en", bus.oBufW2En, exp_en);
            for (int b = 0; b < OBufBank; b++) begin
                if (exp_en[b]) begin
                    chk($sformatf("w2_addr[%0d]", b), bus.oBufW2Addr[b], exp_addr[b]);
                    chk($sformatf("w2_data[%0d]", b), bus.oBufW2Data[b], exp_data[b]);
                end
            end
        end

        gm = 1'b0;
        gv = 1'b0;
        if (!rst) begin
            if (bus.mValid && bus.vValid) begin
                conf = !MERGE || ((bus.mWEn & bus.vWEn) != '0);
                if (conf) begin
                    gm = (m_ptr == 0);
                    gv = (m_ptr == 1);
                end else begin
                    gm = 1'b1;
                    gv = 1'b1;
                end
            end else begin
                gm = bus.mValid;
                gv = bus.vValid;
            end
        end
        chk("mReady", bus.mReady, gm);
        chk("vReady", bus.vReady, gv);
        chk("idle", bus.idle, rst || (!bus.mValid && !bus.vValid && exp_en == '0));

        if (rst || !bus.mValid || bus.mReady) begin
            mwait = 0;
        end else begin
            mwait++;
            nchecks++;
            if (mwait >= 2) begin
                nerrors++;
                $display("FAIL m_starve: waited %0d cycles, required < 2", mwait);
            end
        end
        if (rst || !bus.vValid || bus.vReady) begin
            vwait = 0;
        end else begin
            vwait++;
            nchecks++;
            if (vwait >= 2) begin
                nerrors++;
                $display("FAIL v_starve: waited %0d cycles, required < 2", vwait);
            end
        end

        exp_en   = '0;
        exp_addr = '0;
        exp_data = '0;
        if (rst) begin
            m_ptr   = int'(RST_PRIO);
            exp_any = 1'b0;
        end else begin
            exp_any = gm || gv;
            for (int b = 0; b < OBufBank; b++) begin
                if (gm && bus.mWEn[b]) begin
                    exp_en[b] = 1'b1; exp_addr[b] = bus.mWAddr[b]; exp_data[b] = bus.mWData[b];
                end else if (gv && bus.vWEn[b]) begin
                    exp_en[b] = 1'b1; exp_addr[b] = bus.vWAddr[b]; exp_data[b] = bus.vWData[b];
                end
            end
            if (gm && !gv) m_ptr = 1;
            else if (gv && !gm) m_ptr = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic v, input obuf_en_t en, input logic [7:0] a, input logic [31:0] d);
        bus.mValid = v; bus.mWEn = en; bus.mWAddr = {OBufBank{a}}; bus.mWData = {OBufBank{d}};
    endtask

    task automatic set_v(input logic v, input obuf_en_t en, input logic [7:0] a, input logic [31:0] d);
        bus.vValid = v; bus.vWEn = en; bus.vWAddr = {OBufBank{a}}; bus.vWData = {OBufBank{d}};
    endtask

    function automatic obuf_en_t rand_en();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return 4'b0011;
            2:       return 4'b1100;
            3:       return obuf_en_t'(1 << $urandom_range(0, 3));
            default: return obuf_en_t'($urandom);
        endcase
    endfunction

    initial begin
        logic am, av;
        rst = 1'b1;
        set_m(0, '0, 0, 0);
        set_v(0, '0, 0, 0);

        step();
        set_m(1, 4'b0011, 8'd5, 32'hA);
        @(negedge clk);
        chk("rst_mReady", bus.mReady, 1'b0);
        chk("rst_idle", bus.idle, 1'b1);

        step(); rst = 1'b0;
        @(negedge clk);
        chk("first_mReady", bus.mReady, 1'b1);

        step();
        set_m(1, 4'b0001, 8'd1, 32'h11);
        set_v(1, 4'b0001, 8'd2, 32'h22);
        @(negedge clk);
        chk("first_w2_en", bus.oBufW2En, 4'b0011);
        chk("first_w2_addr0", bus.oBufW2Addr[0], 8'd5);
        chk("first_w2_data0", bus.oBufW2Data[0], 32'hA);
        chk("ptrV_vReady", bus.vReady, 1'b1);
        chk("ptrV_mReady", bus.mReady, 1'b0);

        step();
        set_v(0, '0, 0, 0);
        @(negedge clk);
        chk("v_beat_addr0", bus.oBufW2Addr[0], 8'd2);
        chk("held_m_ready", bus.mReady, 1'b1);

        step();
        set_m(0, '0, 0, 0);
        set_v(1, 4'b0000, 8'd3, 32'h33);
        @(negedge clk);
        chk("zero_en_vReady", bus.vReady, 1'b1);

        step();
        set_m(1, 4'b0001, 8'd1, 32'h11);
        set_v(1, 4'b0001, 8'd2, 32'h22);
        @(negedge clk);
        chk("zero_en_w2_en", bus.oBufW2En, 4'b0000);
        chk("alt0_mReady", bus.mReady, 1'b1);
        chk("alt0_vReady", bus.vReady, 1'b0);
        for (int i = 1; i < 4; i++) begin
            step();
            @(negedge clk);
            chk($sformatf("alt%0d_mReady", i), bus.mReady, (i % 2) == 0);
            chk($sformatf("alt%0d_vReady", i), bus.vReady, (i % 2) == 1);
            chk($sformatf("alt%0d_addr0", i), bus.oBufW2Addr[0], ((i - 1) % 2 == 0) ? 8'd1 : 8'd2);
        end

        step();
        set_m(1, 4'b0011, 8'd3, 32'h33);
        set_v(1, 4'b1100, 8'd4, 32'h44);
        @(negedge clk);
        chk("alt3_out_addr0", bus.oBufW2Addr[0], 8'd2);
`ifdef OBUF_ARB_MERGE_EN
        chk("merge_mReady", bus.mReady, 1'b1);
        chk("merge_vReady", bus.vReady, 1'b1);
        step();
        set_m(1, 4'b0001, 8'd5, 32'h55);
        set_v(1, 4'b0001, 8'd6, 32'h66);
        @(negedge clk);
        chk("merge_w2_en", bus.oBufW2En, 4'b1111);
        chk("merge_addr0", bus.oBufW2Addr[0], 8'd3);
        chk("merge_addr3", bus.oBufW2Addr[3], 8'd4);
        chk("merge_ptr_mReady", bus.mReady, 1'b1);
        step();
        set_m(0, '0, 0, 0);
        @(negedge clk);
        chk("merge_loser_vReady", bus.vReady, 1'b1);
`else
        chk("nomerge_mReady", bus.mReady, 1'b1);
        chk("nomerge_vReady", bus.vReady, 1'b0);
        step();
        set_m(1, 4'b0001, 8'd5, 32'h55);
        @(negedge clk);
        chk("nomerge_w2_en", bus.oBufW2En, 4'b0011);
        chk("nomerge_next_vReady", bus.vReady, 1'b1);
        chk("nomerge_next_mReady", bus.mReady, 1'b0);
        step();
        set_v(0, '0, 0, 0);
        @(negedge clk);
        chk("nomerge_loser_mReady", bus.mReady, 1'b1);
`endif

        step();
        set_v(0, '0, 0, 0);
        set_m(1, 4'b0010, 8'd7, 32'h77);
        @(negedge clk);
        chk("pre_rst_mReady", bus.mReady, 1'b1);

        step();
        rst = 1'b1;
        set_m(0, '0, 0, 0);
        @(negedge clk);
        chk("mid_rst_idle", bus.idle, 1'b1);

        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_w2_en", bus.oBufW2En, 4'b0000);
        chk("post_rst_idle", bus.idle, 1'b1);

        step();
        set_m(1, 4'b0001, 8'd8, 32'h88);
        set_v(1, 4'b0001, 8'd9, 32'h99);
        @(negedge clk);
        chk("rst_prio_mReady", bus.mReady, RST_PRIO == 1'b0);
        chk("rst_prio_vReady", bus.vReady, RST_PRIO == 1'b1);

        step();
        if (bus.mValid && RST_PRIO == 1'b0) set_m(0, '0, 0, 0);
        else set_v(0, '0, 0, 0);
        step();
        set_m(0, '0, 0, 0);
        set_v(0, '0, 0, 0);

        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            am = bus.mValid && bus.mReady;
            av = bus.vValid && bus.vReady;
            step();
            rst = ($urandom_range(0, 399) == 0);
            if (!bus.mValid || am) begin
                set_m($urandom_range(0, 99) < 70, rand_en(), 8'h0, 32'h0);
                bus.mWAddr = obuf_addr_vec_t'($urandom);
                bus.mWData = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!bus.vValid || av) begin
                set_v($urandom_range(0, 99) < 70, rand_en(), 8'h0, 32'h0);
                bus.vWAddr = obuf_addr_vec_t'($urandom);
                bus.vWData = {$urandom, $urandom, $urandom, $urandom};
            end
        end

        step();
        rst = 1'b0;
        set_m(0, '0, 0, 0);
        set_v(0, '0, 0, 0);
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
